// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings for the execute stage: ALU ops, branch conditions, writeback sources.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;

    // ALU operation select; codes 11..15 are reserved and yield zero
    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluPassB = 4'd10
    } alu_sel_e;

    // Branch condition codes (funct3)
    localparam logic [2:0] Funct3Beq  = 3'b000;
    localparam logic [2:0] Funct3Bne  = 3'b001;
    localparam logic [2:0] Funct3Blt  = 3'b100;
    localparam logic [2:0] Funct3Bge  = 3'b101;
    localparam logic [2:0] Funct3Bltu = 3'b110;
    localparam logic [2:0] Funct3Bgeu = 3'b111;

    // Writeback source select
    typedef enum logic [1:0] {
        WbDmem = 2'd0,
        WbAlu  = 2'd1,
        WbPc4  = 2'd2
    } wb_sel_e;

endpackage

// File: rtl/ex_stage_if.sv
// Bundle of ID/EX inputs, forwarding sources and EX/MA outputs of the execute stage.
interface ex_stage_if #(
    parameter int unsigned XLEN = 32
);
    // Pipeline control
    logic            stall_in;
    logic            flush_in;
    logic            valid_in;
    // ID/EX payload
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] pcPlus4_in;
    logic [XLEN-1:0] DataA_in;
    logic [XLEN-1:0] DataB_in;
    logic [4:0]      AddrA_in;
    logic [4:0]      AddrB_in;
    logic [4:0]      AddrD_in;
    logic [XLEN-1:0] imm_in;
    logic [3:0]      ALUSel_in;
    logic            ASel_in;
    logic            BSel_in;
    logic            BrUn_in;
    logic            Branch_in;
    logic            Jump_in;
    logic            RegWEn_in;
    logic            MemRW_in;
    logic [1:0]      WBSel_in;
    logic [2:0]      funct3_in;
    // Forwarding sources
    logic            ma_RegWEn;
    logic            wb_RegWEn;
    logic [4:0]      ma_AddrD;
    logic [4:0]      wb_AddrD;
    logic [XLEN-1:0] ma_Data;
    logic [XLEN-1:0] wb_Data;
    // Redirect and EX/MA outputs
    logic            PCSel_out;
    logic [XLEN-1:0] pc_target_out;
    logic            RegWEn_out;
    logic            MemRW_out;
    logic [1:0]      WBSel_out;
    logic [2:0]      funct3_out;
    logic [XLEN-1:0] ALU_Result_out;
    logic [XLEN-1:0] DataW_out;
    logic [XLEN-1:0] pcPlus4_out;
    logic [4:0]      AddrD_out;

    // Upstream side: drives the instruction and forwarding sources
    modport master (
        output stall_in, flush_in, valid_in, pc_in, pcPlus4_in, DataA_in, DataB_in,
               AddrA_in, AddrB_in, AddrD_in, imm_in, ALUSel_in, ASel_in, BSel_in, BrUn_in,
               Branch_in, Jump_in, RegWEn_in, MemRW_in, WBSel_in, funct3_in,
               ma_RegWEn, wb_RegWEn, ma_AddrD, wb_AddrD, ma_Data, wb_Data,
        input  PCSel_out, pc_target_out, RegWEn_out, MemRW_out, WBSel_out, funct3_out,
               ALU_Result_out, DataW_out, pcPlus4_out, AddrD_out
    );

    // Execute stage side
    modport slave (
        input  stall_in, flush_in, valid_in, pc_in, pcPlus4_in, DataA_in, DataB_in,
               AddrA_in, AddrB_in, AddrD_in, imm_in, ALUSel_in, ASel_in, BSel_in, BrUn_in,
               Branch_in, Jump_in, RegWEn_in, MemRW_in, WBSel_in, funct3_in,
               ma_RegWEn, wb_RegWEn, ma_AddrD, wb_AddrD, ma_Data, wb_Data,
        output PCSel_out, pc_target_out, RegWEn_out, MemRW_out, WBSel_out, funct3_out,
               ALU_Result_out, DataW_out, pcPlus4_out, AddrD_out
    );

endinterface

// File: rtl/ex_alu.sv
// Combinational RV32I ALU: result = op(A, B); shift amount is B[4:0].
module ex_alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [3:0]      i_alu_sel,
    output logic [XLEN-1:0] o_result
);
    import rv32i_pkg::*;

    logic [4:0] w_shamt;
    assign w_shamt = i_b[4:0];

    // Operation decode; reserved codes fall through to zero
    always_comb begin
        o_result = '0;
        case (i_alu_sel)
            AluAdd:   o_result = i_a + i_b;
            AluSub:   o_result = i_a - i_b;
            AluSll:   o_result = i_a << w_shamt;
            AluSlt:   o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            AluSltu:  o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            AluXor:   o_result = i_a ^ i_b;
            AluSrl:   o_result = i_a >> w_shamt;
            AluSra:   o_result = $unsigned($signed(i_a) >>> w_shamt);
            AluOr:    o_result = i_a | i_b;
            AluAnd:   o_result = i_a & i_b;
            AluPassB: o_result = i_b;
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution and the EX/MA register.
module ex_stage #(
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic       clk,
    input  logic       reset,
    ex_stage_if.slave  bus
);
    import rv32i_pkg::*;

    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_alu;
    logic            w_eq;
    logic            w_lt;
    logic            w_taken;

    logic            r_regwen;
    logic            r_memrw;
    logic [1:0]      r_wbsel;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_dataw;
    logic [XLEN-1:0] r_pc4;
    logic [4:0]      r_addrd;

    // Forwarding for rs1/rs2: MA beats WB, x0 is never forwarded
    always_comb begin
        w_fwd_a = bus.DataA_in;
        if (bus.ma_RegWEn && (bus.ma_AddrD != 5'd0) && (bus.ma_AddrD == bus.AddrA_in)) begin
            w_fwd_a = bus.ma_Data;
        end else if (bus.wb_RegWEn && (bus.wb_AddrD != 5'd0) &&
                     (bus.wb_AddrD == bus.AddrA_in)) begin
            w_fwd_a = bus.wb_Data;
        end
        w_fwd_b = bus.DataB_in;
        if (bus.ma_RegWEn && (bus.ma_AddrD != 5'd0) && (bus.ma_AddrD == bus.AddrB_in)) begin
            w_fwd_b = bus.ma_Data;
        end else if (bus.wb_RegWEn && (bus.wb_AddrD != 5'd0) &&
                     (bus.wb_AddrD == bus.AddrB_in)) begin
            w_fwd_b = bus.wb_Data;
        end
    end

    assign w_op_a = bus.ASel_in ? bus.pc_in  : w_fwd_a;
    assign w_op_b = bus.BSel_in ? bus.imm_in : w_fwd_b;

    ex_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .i_a       (w_op_a),
        .i_b       (w_op_b),
        .i_alu_sel (bus.ALUSel_in),
        .o_result  (w_alu)
    );

    // Branch compare always uses the forwarded register values, not the ALU operands
    assign w_eq = (w_fwd_a == w_fwd_b);
    assign w_lt = bus.BrUn_in ? (w_fwd_a < w_fwd_b) : ($signed(w_fwd_a) < $signed(w_fwd_b));

    // Branch condition decode from funct3
    always_comb begin
        w_taken = 1'b0;
        case (bus.funct3_in)
            Funct3Beq:              w_taken = w_eq;
            Funct3Bne:              w_taken = !w_eq;
            Funct3Blt, Funct3Bltu:  w_taken = w_lt;
            Funct3Bge, Funct3Bgeu:  w_taken = !w_lt;
            default:                w_taken = 1'b0;
        endcase
    end

    // Gated by stall so a held instruction redirects only once
    assign bus.PCSel_out = !reset && bus.valid_in && !bus.stall_in && !bus.flush_in &&
                           (bus.Jump_in || (bus.Branch_in && w_taken));
    assign bus.pc_target_out = {w_alu[XLEN-1:1], 1'b0};

    // EX/MA register: reset, then flush over stall, then capture or bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_regwen <= 1'b0;
            r_memrw  <= 1'b0;
            r_wbsel  <= '0;
            r_funct3 <= '0;
            r_alu    <= '0;
            r_dataw  <= '0;
            r_pc4    <= RESET_PC;
            r_addrd  <= '0;
        end else if (bus.flush_in || (!bus.stall_in && !bus.valid_in)) begin
            r_regwen <= 1'b0;
            r_memrw  <= 1'b0;
            r_wbsel  <= '0;
            r_funct3 <= '0;
            r_alu    <= '0;
            r_dataw  <= '0;
            r_pc4    <= '0;
            r_addrd  <= '0;
        end else if (!bus.stall_in) begin
            r_regwen <= bus.RegWEn_in;
            r_memrw  <= bus.MemRW_in;
            r_wbsel  <= bus.WBSel_in;
            r_funct3 <= bus.funct3_in;
            r_alu    <= w_alu;
            r_dataw  <= w_fwd_b;
            r_pc4    <= bus.pcPlus4_in;
            r_addrd  <= bus.AddrD_in;
        end
    end

    assign bus.RegWEn_out     = r_regwen;
    assign bus.MemRW_out      = r_memrw;
    assign bus.WBSel_out      = r_wbsel;
    assign bus.funct3_out     = r_funct3;
    assign bus.ALU_Result_out = r_alu;
    assign bus.DataW_out      = r_dataw;
    assign bus.pcPlus4_out    = r_pc4;
    assign bus.AddrD_out      = r_addrd;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, stall/flush and async-reset sequences, random
// stimulus against a behavioural model.
module tb_ex_stage;
    import rv32i_pkg::*;

    localparam logic [31:0] RstPc = 32'h8000_0000;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    ex_stage_if #(.XLEN(32)) bus ();

    ex_stage #(
        .XLEN     (32),
        .RESET_PC (RstPc)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] da;
        logic [31:0] db;
        logic        ma_we;
        logic [4:0]  ma_rd;
        logic [31:0] ma_d;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_d;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        asel;
        logic        bsel;
        logic        brun;
        logic        br;
        logic        jmp;
        logic        regwen;
        logic [2:0]  f3;
        logic        e_pcsel;
        logic [31:0] e_tgt;
        logic [31:0] e_alu;
        logic [31:0] e_dataw;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.stall_in = 0; bus.flush_in = 0; bus.valid_in = 0;
        bus.pc_in = 0; bus.pcPlus4_in = 0; bus.DataA_in = 0; bus.DataB_in = 0;
        bus.AddrA_in = 0; bus.AddrB_in = 0; bus.AddrD_in = 0; bus.imm_in = 0;
        bus.ALUSel_in = 0; bus.ASel_in = 0; bus.BSel_in = 0; bus.BrUn_in = 0;
        bus.Branch_in = 0; bus.Jump_in = 0; bus.RegWEn_in = 0; bus.MemRW_in = 0;
        bus.WBSel_in = 0; bus.funct3_in = 0;
        bus.ma_RegWEn = 0; bus.wb_RegWEn = 0; bus.ma_AddrD = 0; bus.wb_AddrD = 0;
        bus.ma_Data = 0; bus.wb_Data = 0;
    endtask

    task automatic drive_vec(input vec_t v);
        idle();
        bus.valid_in = 1;
        bus.AddrA_in = v.ra; bus.AddrB_in = v.rb; bus.DataA_in = v.da; bus.DataB_in = v.db;
        bus.ma_RegWEn = v.ma_we; bus.ma_AddrD = v.ma_rd; bus.ma_Data = v.ma_d;
        bus.wb_RegWEn = v.wb_we; bus.wb_AddrD = v.wb_rd; bus.wb_Data = v.wb_d;
        bus.pc_in = v.pc; bus.pcPlus4_in = v.pc4; bus.imm_in = v.imm; bus.ALUSel_in = v.alu;
        bus.ASel_in = v.asel; bus.BSel_in = v.bsel; bus.BrUn_in = v.brun;
        bus.Branch_in = v.br; bus.Jump_in = v.jmp; bus.RegWEn_in = v.regwen;
        bus.funct3_in = v.f3; bus.AddrD_in = 5'd9; bus.WBSel_in = WbAlu;
    endtask

    // ---------------- behavioural reference ----------------
    function automatic logic [31:0] fwd_m(input logic [4:0] src, input logic [31:0] rf,
                                          input logic mwe, input logic [4:0] mrd,
                                          input logic [31:0] md, input logic wwe,
                                          input logic [4:0] wrd, input logic [31:0] wd);
        if (src == 0) return rf;
        if (mwe && mrd == src) return md;
        if (wwe && wrd == src) return wd;
        return rf;
    endfunction

    function automatic logic [31:0] alu_m(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] s);
        int          sa;
        int          sb;
        int unsigned sh;
        sa = a;
        sb = b;
        sh = b % 32;
        case (s)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << sh;
            4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd4:  return (a < b) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return a >> sh;
            4'd7:  return sa >>> sh;
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic taken_m(input logic [31:0] a, input logic [31:0] b,
                                     input logic un, input logic [2:0] f3);
        int   sa;
        int   sb;
        logic lt;
        sa = a;
        sb = b;
        lt = un ? (a < b) : (sa < sb);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 4))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] fa, fb, opa, opb, res;
        logic        e_pcsel;
        logic        m_regwen, m_memrw;
        logic [1:0]  m_wbsel;
        logic [2:0]  m_f3;
        logic [4:0]  m_rd;
        logic [31:0] m_alu, m_dw, m_pc4;

        total = 0;
        bad = 0;
        idle();

        // Vector table: forwarding, priority, x0, branches, jumps, ALU corners
        vecs[0]  = '{ra:5, da:1, db:23, ma_we:1, ma_rd:5, ma_d:100, pc4:32'h14, alu:AluAdd,
                     regwen:1, e_pcsel:0, e_tgt:122, e_alu:123, e_dataw:23, default:'0};
        vecs[1]  = '{ra:3, da:1, ma_we:1, ma_rd:3, ma_d:7, wb_we:1, wb_rd:3, wb_d:9,
                     regwen:1, e_tgt:6, e_alu:7, default:'0};
        vecs[2]  = '{ra:0, da:0, ma_we:1, ma_rd:0, ma_d:55, regwen:1, default:'0};
        vecs[3]  = '{ra:1, da:32'hFFFF_FFFF, rb:2, db:1, asel:1, pc:32'h40, bsel:1, imm:8,
                     br:1, f3:3'b100, e_pcsel:1, e_tgt:32'h48, e_alu:32'h48, e_dataw:1,
                     default:'0};
        vecs[4]  = '{ra:1, da:32'hFFFF_FFFF, rb:2, db:1, asel:1, pc:32'h40, bsel:1, imm:8,
                     br:1, brun:1, f3:3'b110, e_pcsel:0, e_tgt:32'h48, e_alu:32'h48,
                     e_dataw:1, default:'0};
        vecs[5]  = '{ra:1, da:32'h1001, bsel:1, imm:2, jmp:1, regwen:1, pc4:32'h104,
                     e_pcsel:1, e_tgt:32'h1002, e_alu:32'h1003, default:'0};
        vecs[6]  = '{ra:4, da:50, rb:7, db:3, wb_we:1, wb_rd:7, wb_d:10, alu:AluSub,
                     regwen:1, e_tgt:40, e_alu:40, e_dataw:10, default:'0};
        vecs[7]  = '{ra:1, da:5, rb:2, db:9, ma_we:1, ma_rd:2, ma_d:5, br:1, f3:3'b001,
                     e_pcsel:0, e_tgt:10, e_alu:10, e_dataw:5, default:'0};
        vecs[8]  = '{ra:1, da:32'h8000_0000, bsel:1, imm:4, alu:AluSra,
                     e_tgt:32'hF800_0000, e_alu:32'hF800_0000, default:'0};
        vecs[9]  = '{bsel:1, imm:32'h1234_5000, alu:AluPassB, regwen:1,
                     e_tgt:32'h1234_5000, e_alu:32'h1234_5000, default:'0};
        vecs[10] = '{ra:1, da:7, rb:2, db:3, alu:4'd13, e_dataw:3, default:'0};
        vecs[11] = '{ra:1, da:0, ma_we:1, ma_rd:1, ma_d:32'hFFFF_FFFE, rb:2,
                     db:32'hFFFF_FFFE, asel:1, pc:32'h200, bsel:1, imm:32'hFFFF_FFF0, br:1,
                     f3:3'b101, e_pcsel:1, e_tgt:32'h1F0, e_alu:32'h1F0,
                     e_dataw:32'hFFFF_FFFE, default:'0};

        // Reset state, reached asynchronously before any clock edge
        reset = 0;
        #1 reset = 1;
        #2;
        chk("rst_alu", bus.ALU_Result_out, 0);
        chk("rst_pc4", bus.pcPlus4_out, RstPc);
        chk("rst_ctl", {bus.RegWEn_out, bus.MemRW_out, bus.WBSel_out, bus.funct3_out,
                        bus.AddrD_out}, 0);
        @(negedge clk);
        reset = 0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive_vec(vecs[i]);
            #1;
            chk($sformatf("v%0d_pcsel", i), bus.PCSel_out, vecs[i].e_pcsel);
            chk($sformatf("v%0d_tgt", i), bus.pc_target_out, vecs[i].e_tgt);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_alu", i), bus.ALU_Result_out, vecs[i].e_alu);
            chk($sformatf("v%0d_dataw", i), bus.DataW_out, vecs[i].e_dataw);
            chk($sformatf("v%0d_regwen", i), bus.RegWEn_out, vecs[i].regwen);
            chk($sformatf("v%0d_pc4", i), bus.pcPlus4_out, vecs[i].pc4);
        end

        // Store captured, held through a 3-cycle stall, then flushed while still stalled
        @(negedge clk);
        idle();
        bus.valid_in = 1; bus.MemRW_in = 1; bus.AddrA_in = 1; bus.DataA_in = 32'h100;
        bus.BSel_in = 1; bus.imm_in = 4; bus.AddrB_in = 2; bus.DataB_in = 32'hDEAD;
        bus.funct3_in = 3'b010; bus.pcPlus4_in = 32'h300;
        @(posedge clk);
        #1;
        chk("sw_memrw", bus.MemRW_out, 1);
        chk("sw_alu", bus.ALU_Result_out, 32'h104);
        chk("sw_dataw", bus.DataW_out, 32'hDEAD);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.stall_in = 1; bus.Jump_in = 1; bus.DataA_in = $urandom;
            bus.MemRW_in = 0; bus.pcPlus4_in = $urandom;
            #1;
            chk($sformatf("stall%0d_pcsel", c), bus.PCSel_out, 0);
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_memrw", c), bus.MemRW_out, 1);
            chk($sformatf("stall%0d_alu", c), bus.ALU_Result_out, 32'h104);
            chk($sformatf("stall%0d_dataw", c), bus.DataW_out, 32'hDEAD);
            chk($sformatf("stall%0d_pc4", c), bus.pcPlus4_out, 32'h300);
        end
        @(negedge clk);
        bus.flush_in = 1; bus.RegWEn_in = 1; bus.MemRW_in = 1;
        #1;
        chk("flush_pcsel", bus.PCSel_out, 0);
        @(posedge clk);
        #1;
        chk("flush_memrw", bus.MemRW_out, 0);
        chk("flush_regwen", bus.RegWEn_out, 0);
        chk("flush_alu", bus.ALU_Result_out, 0);
        chk("flush_pc4", bus.pcPlus4_out, 0);

        // Asynchronous reset between edges
        @(negedge clk);
        idle();
        bus.valid_in = 1; bus.RegWEn_in = 1; bus.DataA_in = 32'h77; bus.DataB_in = 32'h11;
        bus.AddrA_in = 1; bus.AddrB_in = 2; bus.pcPlus4_in = 32'h55C; bus.AddrD_in = 5'd4;
        @(posedge clk);
        #1;
        chk("pre_rst_alu", bus.ALU_Result_out, 32'h88);
        #2;
        reset = 1; bus.Jump_in = 1;
        #1;
        chk("arst_alu", bus.ALU_Result_out, 0);
        chk("arst_pc4", bus.pcPlus4_out, RstPc);
        chk("arst_regwen", bus.RegWEn_out, 0);
        chk("arst_pcsel", bus.PCSel_out, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 0; bus.Jump_in = 0; bus.DataA_in = 32'h5; bus.DataB_in = 32'h6;
        @(posedge clk);
        #1;
        chk("post_rst_alu", bus.ALU_Result_out, 32'hB);
        chk("post_rst_pc4", bus.pcPlus4_out, 32'h55C);
        chk("post_rst_rd", bus.AddrD_out, 4);

        // Random stimulus against the reference model, starting from reset
        @(negedge clk);
        idle();
        reset = 1;
        @(negedge clk);
        reset = 0;
        m_regwen = 0; m_memrw = 0; m_wbsel = 0; m_f3 = 0; m_rd = 0;
        m_alu = 0; m_dw = 0; m_pc4 = RstPc;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            bus.stall_in = ($urandom_range(0, 3) == 0);
            bus.flush_in = ($urandom_range(0, 7) == 0);
            bus.valid_in = ($urandom_range(0, 3) != 0);
            bus.pc_in = $urandom; bus.pcPlus4_in = $urandom;
            bus.DataA_in = rval(); bus.DataB_in = rval(); bus.imm_in = rval();
            bus.AddrA_in = 5'($urandom_range(0, 3)); bus.AddrB_in = 5'($urandom_range(0, 3));
            bus.AddrD_in = 5'($urandom_range(0, 31));
            bus.ALUSel_in = 4'($urandom_range(0, 15));
            bus.ASel_in = 1'($urandom); bus.BSel_in = 1'($urandom); bus.BrUn_in = 1'($urandom);
            bus.Branch_in = 1'($urandom); bus.Jump_in = ($urandom_range(0, 5) == 0);
            bus.RegWEn_in = 1'($urandom); bus.MemRW_in = 1'($urandom);
            bus.WBSel_in = 2'($urandom_range(0, 2)); bus.funct3_in = 3'($urandom);
            bus.ma_RegWEn = 1'($urandom); bus.wb_RegWEn = 1'($urandom);
            bus.ma_AddrD = 5'($urandom_range(0, 3)); bus.wb_AddrD = 5'($urandom_range(0, 3));
            bus.ma_Data = rval(); bus.wb_Data = rval();
            #1;
            fa = fwd_m(bus.AddrA_in, bus.DataA_in, bus.ma_RegWEn, bus.ma_AddrD, bus.ma_Data,
                       bus.wb_RegWEn, bus.wb_AddrD, bus.wb_Data);
            fb = fwd_m(bus.AddrB_in, bus.DataB_in, bus.ma_RegWEn, bus.ma_AddrD, bus.ma_Data,
                       bus.wb_RegWEn, bus.wb_AddrD, bus.wb_Data);
            opa = bus.ASel_in ? bus.pc_in : fa;
            opb = bus.BSel_in ? bus.imm_in : fb;
            res = alu_m(opa, opb, bus.ALUSel_in);
            e_pcsel = bus.valid_in && !bus.stall_in && !bus.flush_in &&
                      (bus.Jump_in ||
                       (bus.Branch_in && taken_m(fa, fb, bus.BrUn_in, bus.funct3_in)));
            chk($sformatf("rnd%0d_pcsel", n), bus.PCSel_out, e_pcsel);
            chk($sformatf("rnd%0d_tgt", n), bus.pc_target_out, res & 32'hFFFF_FFFE);
            if (bus.flush_in || (!bus.stall_in && !bus.valid_in)) begin
                m_regwen = 0; m_memrw = 0; m_wbsel = 0; m_f3 = 0; m_rd = 0;
                m_alu = 0; m_dw = 0; m_pc4 = 0;
            end else if (!bus.stall_in) begin
                m_regwen = bus.RegWEn_in; m_memrw = bus.MemRW_in; m_wbsel = bus.WBSel_in;
                m_f3 = bus.funct3_in; m_rd = bus.AddrD_in; m_alu = res; m_dw = fb;
                m_pc4 = bus.pcPlus4_in;
            end
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_alu", n), bus.ALU_Result_out, m_alu);
            chk($sformatf("rnd%0d_dataw", n), bus.DataW_out, m_dw);
            chk($sformatf("rnd%0d_pc4", n), bus.pcPlus4_out, m_pc4);
            chk($sformatf("rnd%0d_ctl", n), {bus.RegWEn_out, bus.MemRW_out, bus.WBSel_out,
                                              bus.funct3_out, bus.AddrD_out},
                {m_regwen, m_memrw, m_wbsel, m_f3, m_rd});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
RV32I execute stage. Sits between the ID/EX register and the memory-access stage.
- Selects forwarded operands and computes the ALU result.
- Resolves branches and jumps, and drives the PC redirect.
- Contains the EX/MA pipeline register, with stall and flush.
- Its registered outputs feed the memory-access stage directly: RegWEn, MemRW, WBSel, funct3, ALU_Result, DataW, pcPlus4, AddrD.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, value that pcPlus4_out resets to.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- stall_in  input  1  hold EX/MA contents (downstream not ready).
- flush_in  input  1  replace the next EX/MA entry with a bubble.
- valid_in  input  1  ID/EX holds a real instruction.
- pc_in, pcPlus4_in  input  32  instruction PC and PC+4.
- DataA_in, DataB_in  input  32  register-file read data for rs1 and rs2.
- AddrA_in, AddrB_in, AddrD_in  input  5  rs1, rs2, rd.
- imm_in  input  32  sign-extended immediate.
- ALUSel_in  input  4  ALU operation.
- ASel_in, BSel_in  input  1  operand A: 0 = rs1, 1 = pc; operand B: 0 = rs2, 1 = imm.
- BrUn_in, Branch_in, Jump_in  input  1  unsigned compare, conditional branch, JAL/JALR.
- RegWEn_in, MemRW_in  input  1  writeback enable, store enable.
- WBSel_in  input  2  writeback source.
- funct3_in  input  3  branch condition and memory size.
- ma_RegWEn, wb_RegWEn  input  1  forwarding-source write enables.
- ma_AddrD, wb_AddrD  input  5  forwarding-source destination registers.
- ma_Data, wb_Data  input  32  forwarding values.
- PCSel_out  output  1  combinational redirect request.
- pc_target_out  output  32  combinational redirect target.
- RegWEn_out, MemRW_out  output  1  registered.
- WBSel_out  output  2  registered.
- funct3_out  output  3  registered.
- ALU_Result_out, DataW_out, pcPlus4_out  output  32  registered.
- AddrD_out  output  5  registered.

Behaviour:
- Forwarding, applied to rs1 and rs2 independently:
  - Use the MA value if ma_RegWEn and ma_AddrD equals the source register and ma_AddrD is not 0.
  - Otherwise use the WB value under the same conditions.
  - Otherwise use the register-file value.
  - MA beats WB; x0 is never forwarded.
- Operand muxes: A = ASel ? pc_in : fwdA. B = BSel ? imm_in : fwdB.
- ALUSel encodings:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 PASSB, used for LUI.
  - 11–15 produce 0.
  - Shift amount is B[4:0].
  - SLT and SLTU return 32'h0/32'h1.
  - All arithmetic wraps modulo 2^32.
- Branch compare: on fwdA vs fwdB, signed unless BrUn_in. taken is decoded from funct3: 000 eq, 001 ne, 100 lt, 101 ge, 110 lt, 111 ge; other codes give 0.
- Redirect:
  - pc_target_out = ALU result with bit 0 cleared.
  - PCSel_out = valid_in & !stall_in & !flush_in & (Jump_in | (Branch_in & taken)).
  - PCSel_out is never asserted during stall, so a redirect fires exactly once.
- DataW_out captures fwdB, so store data is always the forwarded value.
- EX/MA register update, per rising clk (priority order):
  - reset (async) → all outputs 0 and pcPlus4_out = RESET_PC.
  - flush_in → bubble: RegWEn_out = 0, MemRW_out = 0, all other fields 0. Flush beats stall when both are high.
  - stall_in → hold every field.
  - else if valid_in → capture: control from the inputs, ALU_Result_out = ALU result, DataW_out = fwdB, and pcPlus4, funct3, WBSel, AddrD passed through.
  - else → bubble.
- Latency: 1 cycle from ID/EX to the outputs. PCSel_out and pc_target_out are same-cycle combinational.
- Reset asserted mid-operation: the register is cleared immediately and PCSel_out is forced to 0 while reset is high.

Decomposition:
- Shared package rv32i_pkg:
  - ALUSel codes.
  - Branch funct3 codes.
  - WBSel codes: 0 DMEM, 1 ALU, 2 PC+4.
  - XLEN.
- One sub-module: ex_alu, purely combinational; it takes A, B and ALUSel and returns the result.
- The forwarding, compare and EX/MA register logic live inline in ex_stage.

Test Plan:
- ADD forwarding from MA: rs1 = x5, ma_AddrD = 5, ma_Data = 100, DataB = 23, ALUSel = ADD → next cycle ALU_Result_out = 123 and RegWEn_out = 1.
- MA/WB priority and x0: ma and wb both target x3 (ma_Data = 7, wb_Data = 9) → operand is 7. With rs1 = x0 and ma_AddrD = 0, ma_Data = 55 → operand is DataA_in (0).
- BLT signed vs BLTU: fwdA = 32'hFFFF_FFFF, fwdB = 1, funct3 = 100 → PCSel = 1. Same operands with funct3 = 110 and BrUn = 1 → PCSel = 0. pc_in = 0x40, imm = 8 with ASel = 1 → target = 0x48.
- JALR alignment: rs1 = 0x1001, imm = 2, Jump = 1 → pc_target_out = 0x1002, PCSel = 1, pcPlus4_out registered.
- Stall then flush: capture a SW (MemRW = 1), hold stall_in for 3 cycles → outputs stay constant and PCSel stays 0. Then flush_in together with stall_in → MemRW_out = 0 and RegWEn_out = 0 on the next edge.
- Async reset mid-stream: assert reset between edges → outputs go to 0 and pcPlus4_out = RESET_PC without waiting for a clk edge. After release, the first valid instruction is captured normally.
